// File: rtl/cv32e40p_apu_responder.sv
// rtl/cv32e40p_apu_responder.sv - APU responder: ADD/SUB/MAC/MINU with req/gnt/rvalid handshake
// One operation in flight; the result is computed at accept and released after its latency.
module cv32e40p_apu_responder #(
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NUSFLAGS_CPU = 5,
  parameter int MAC_LAT          = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         apu_req_i,
  output logic                         apu_gnt_o,
  input  logic [APU_NARGS_CPU*32-1:0]  apu_operands_i,
  input  logic [APU_WOP_CPU-1:0]       apu_op_i,
  output logic                         apu_rvalid_o,
  output logic [31:0]                  apu_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]  apu_flags_o,
  output logic                         busy_o
);

  localparam logic [APU_WOP_CPU-1:0] OP_ADD  = APU_WOP_CPU'(0);
  localparam logic [APU_WOP_CPU-1:0] OP_SUB  = APU_WOP_CPU'(1);
  localparam logic [APU_WOP_CPU-1:0] OP_MAC  = APU_WOP_CPU'(2);
  localparam logic [APU_WOP_CPU-1:0] OP_MINU = APU_WOP_CPU'(3);
  localparam logic [2:0]             MAC_CNT = 3'(MAC_LAT - 1);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t                      state, state_next;
  logic [2:0]                  cnt, cnt_next;
  logic                        accept, done;
  logic [31:0]                 op_a, op_b, op_c;
  logic [31:0]                 calc_result;
  logic [APU_NUSFLAGS_CPU-1:0] calc_flags;
  logic [2:0]                  calc_cnt;
  logic [31:0]                 hold_result, last_result;
  logic [APU_NUSFLAGS_CPU-1:0] hold_flags, last_flags;

  assign op_a = apu_operands_i[31:0];
  assign op_b = apu_operands_i[63:32];
  assign op_c = apu_operands_i[95:64];

  always_comb begin
    calc_result = '0;
    calc_flags  = '0;
    calc_cnt    = 3'd0;
    case (apu_op_i)
      OP_ADD: begin
        calc_result   = op_a + op_b;
        calc_flags[1] = (op_a[31] == op_b[31]) && (calc_result[31] != op_a[31]);
      end
      OP_SUB: begin
        calc_result   = op_a - op_b;
        calc_flags[1] = (op_a[31] != op_b[31]) && (calc_result[31] != op_a[31]);
      end
      OP_MAC: begin
        // Low 32 bits of a signed product equal those of the unsigned product.
        calc_result = op_a * op_b + op_c;
        calc_cnt    = MAC_CNT;
      end
      OP_MINU: calc_result = (op_a < op_b) ? op_a : op_b;
      default: calc_flags[0] = 1'b1;
    endcase
  end

  assign done      = (state == EXEC) && (cnt == 3'd0);
  assign apu_gnt_o = rst_n && apu_req_i && ((state == IDLE) || (cnt == 3'd0));
  assign accept    = apu_gnt_o;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (state == IDLE) begin
      if (accept) begin
        state_next = EXEC;
        cnt_next   = calc_cnt;
      end
    end else if (cnt != 3'd0) begin
      cnt_next = cnt - 3'd1;
    end else if (accept) begin
      cnt_next = calc_cnt;
    end else begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      hold_result <= '0;
      hold_flags  <= '0;
      last_result <= '0;
      last_flags  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (done) begin
        last_result <= hold_result;
        last_flags  <= hold_flags;
      end
      if (accept) begin
        hold_result <= calc_result;
        hold_flags  <= calc_flags;
      end
    end
  end

  // The pending result stays hidden until its rvalid cycle; otherwise show the last answer.
  assign apu_rvalid_o = done;
  assign apu_result_o = done ? hold_result : last_result;
  assign apu_flags_o  = done ? hold_flags : last_flags;
  assign busy_o       = (state == EXEC);

endmodule

// File: tb/tb_cv32e40p_apu_responder.sv
// tb/tb_cv32e40p_apu_responder.sv - scoreboard bench for cv32e40p_apu_responder
module tb_cv32e40p_apu_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        apu_req_i = 1'b0;
  logic        apu_gnt_o;
  logic [95:0] apu_operands_i = '0;
  logic [5:0]  apu_op_i = '0;
  logic        apu_rvalid_o;
  logic [31:0] apu_result_o;
  logic [4:0]  apu_flags_o;
  logic        busy_o;

  cv32e40p_apu_responder #(
    .APU_NARGS_CPU(3), .APU_WOP_CPU(6), .APU_NUSFLAGS_CPU(5), .MAC_LAT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .apu_req_i(apu_req_i), .apu_gnt_o(apu_gnt_o),
    .apu_operands_i(apu_operands_i), .apu_op_i(apu_op_i), .apu_rvalid_o(apu_rvalid_o),
    .apu_result_o(apu_result_o), .apu_flags_o(apu_flags_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] res;
    logic [4:0]  fl;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_fl = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model(input logic [5:0] op, input logic [31:0] a, b, c,
                                output logic [31:0] res, output logic [4:0] fl, output int lat);
    longint s;
    res = 32'd0; fl = 5'd0; lat = 1;
    case (op)
      6'd0: begin
        s = longint'($signed(a)) + longint'($signed(b));
        res = s[31:0];
        fl[1] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'd1: begin
        s = longint'($signed(a)) - longint'($signed(b));
        res = s[31:0];
        fl[1] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'd2: begin
        s = longint'($signed(a)) * longint'($signed(b)) + longint'($signed(c));
        res = s[31:0];
        lat = 3;
      end
      6'd3: res = (a < b) ? a : b;
      default: fl[0] = 1'b1;
    endcase
  endfunction

  // Response monitor: every rvalid must match the oldest expectation, in its exact cycle.
  always @(negedge clk) begin
    if (rst_n && apu_rvalid_o) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rvalid cycle %0d result %h", cyc, apu_result_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (apu_result_o !== e.res || apu_flags_o !== e.fl || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL response got res %h fl %b cyc %0d, want res %h fl %b cyc %0d",
                   apu_result_o, apu_flags_o, cyc, e.res, e.fl, e.cyc);
        end
        last_res = e.res;
        last_fl  = e.fl;
      end
    end
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] a, b, c,
                       output int waited, output int gcyc);
    exp_t e;
    int   lat;
    apu_req_i = 1'b1;
    apu_op_i = op;
    apu_operands_i = {c, b, a};
    waited = 0;
    @(negedge clk);
    while (!apu_gnt_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    gcyc = cyc;
    if (!apu_gnt_o) begin
      vectors++;
      miscompares++;
      $display("FAIL grant_timeout op %0d", op);
    end else begin
      model(op, a, b, c, e.res, e.fl, lat);
      e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    apu_req_i = 1'b0;
    apu_operands_i = '1;
    apu_op_i = 6'h3f;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int w, g;
    apu_req_i = 1'b1;
    #1;
    vectors++;
    if ({apu_gnt_o, apu_rvalid_o, busy_o} !== 3'b000 || apu_result_o !== 32'd0 || apu_flags_o !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got gnt %b rv %b busy %b res %h fl %b, want all 0",
               apu_gnt_o, apu_rvalid_o, busy_o, apu_result_o, apu_flags_o);
    end
    apu_req_i = 1'b0;
    idle(3);
    rst_n = 1'b1;
    issue(6'd0, 32'd1, 32'd2, 32'd0, w, g);
    vectors++;
    if (w != 0) begin
      miscompares++;
      $display("FAIL first_accept waited %0d, want 0", w);
    end
    idle(2);
  endtask

  task automatic test_add();
    int w, g;
    issue(6'd0, 32'd5, 32'd7, 32'd0, w, g);
    vectors++;
    if (w != 0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL add_grant waited %0d busy %b, want 0 1", w, busy_o);
    end
    idle(4);
    vectors++;
    if (apu_result_o !== 32'd12 || apu_flags_o !== 5'd0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL add_hold got res %h fl %b busy %b, want 0000000c 00000 0",
               apu_result_o, apu_flags_o, busy_o);
    end
  endtask

  task automatic test_mac();
    int w, g;
    issue(6'd2, -32'sd3, 32'd4, 32'd100, w, g);
    vectors++;
    if (w != 0 || sb[0].res !== 32'd88) begin
      miscompares++;
      $display("FAIL mac_setup waited %0d model %0d, want 0 88", w, sb[0].res);
    end
    #4;
    vectors++;
    if (apu_result_o !== 32'd12 || apu_rvalid_o !== 1'b0 || apu_gnt_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mac_inflight got res %h rv %b, want 0000000c 0", apu_result_o, apu_rvalid_o);
    end
    idle(4);
  endtask

  task automatic test_overflow();
    int w, g;
    issue(6'd0, 32'h7fffffff, 32'd1, 32'd0, w, g);
    idle(1);
    vectors++;
    if (apu_result_o !== 32'h80000000 || apu_flags_o !== 5'b00010) begin
      miscompares++;
      $display("FAIL add_overflow got %h %b, want 80000000 00010", apu_result_o, apu_flags_o);
    end
    issue(6'd1, 32'h80000000, 32'd1, 32'd0, w, g);
    issue(6'd1, 32'd3, 32'd5, 32'd0, w, g);
    idle(2);
  endtask

  task automatic test_busy_hold();
    int w, g, w2, g2;
    issue(6'd2, 32'd6, 32'd7, 32'd8, w, g);
    issue(6'd0, 32'd10, 32'd20, 32'd0, w2, g2);
    vectors++;
    if (w2 != 2 || g2 != g + 3) begin
      miscompares++;
      $display("FAIL held_grant waited %0d at +%0d, want 2 at +3", w2, g2 - g);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    int w, g, g0, tot;
    tot = 0;
    issue(6'd1, 32'd100, 32'd1, 32'd0, w, g0); tot += w;
    issue(6'd3, 32'd9, 32'hffffffff, 32'd0, w, g); tot += w;
    issue(6'd1, 32'd0, 32'd1, 32'd0, w, g); tot += w;
    issue(6'd3, 32'h80000000, 32'd7, 32'd0, w, g); tot += w;
    vectors++;
    if (tot != 0 || g != g0 + 3) begin
      miscompares++;
      $display("FAIL b2b_grants stalls %0d span %0d, want 0 3", tot, g - g0);
    end
    idle(3);
  endtask

  task automatic test_illegal();
    int w, g;
    issue(6'd9, 32'd1, 32'd2, 32'd3, w, g);
    idle(1);
    vectors++;
    if (apu_result_o !== 32'd0 || apu_flags_o !== 5'b00001 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_op got %h %b busy %b, want 0 00001 0", apu_result_o, apu_flags_o, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int w, g;
    issue(6'd2, 32'd2, 32'd3, 32'd4, w, g);
    rst_n = 1'b0;
    sb.delete();
    #1;
    vectors++;
    if (busy_o !== 1'b0 || apu_rvalid_o !== 1'b0 || apu_result_o !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset got busy %b rv %b res %h, want 0 0 0", busy_o, apu_rvalid_o, apu_result_o);
    end
    idle(2);
    rst_n = 1'b1;
    idle(5);
    issue(6'd0, 32'd40, 32'd2, 32'd0, w, g);
    vectors++;
    if (w != 0) begin
      miscompares++;
      $display("FAIL post_reset_add waited %0d, want 0", w);
    end
    idle(2);
  endtask

  task automatic test_random();
    int w, g;
    logic [5:0] op;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(4, 63)) : 6'($urandom_range(0, 3));
      issue(op, $urandom, $urandom, $urandom, w, g);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(6);
    vectors++;
    if (apu_result_o !== last_res || apu_flags_o !== last_fl) begin
      miscompares++;
      $display("FAIL random_hold got %h %b, want %h %b", apu_result_o, apu_flags_o, last_res, last_fl);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mac();
    test_overflow();
    test_busy_hold();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_random();
    idle(4);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL missing_responses %0d outstanding, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
